apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master.sv | 140 ++++++++++++++
 tb/tb_apb_master.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state enum and default bus widths.
// Also used by the UART APB slave.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// APB requester: accepts one command at a time on a valid/ready channel,
// runs the SETUP/ACCESS handshake, and returns a one-cycle response pulse.
// Optional macro APB_MASTER_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT
// consecutive cycles with PREADY low, answering with an error response.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,

    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,

    output logic                PSEL,
    output logic                PENABLE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    apb_state_e state;
    apb_state_e state_nxt;
    logic       accept;
    logic       xfer_end;
    logic       xfer_tmo;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Count consecutive stalled ACCESS cycles; any other cycle restarts the count
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !PREADY && !xfer_tmo) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Abort on the stalled cycle that would bring the count to TIMEOUT
    always_comb begin
        xfer_tmo = (state == ACCESS) && !PREADY && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);

    // No timeout: ACCESS waits for PREADY indefinitely
    always_comb begin
        xfer_tmo = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and phase-dependent bus controls
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        xfer_end  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || xfer_tmo) begin
                    xfer_end  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        accept = cmd_valid && cmd_ready;
    end

    // Latch the accepted command onto the bus and register the response
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= xfer_end;
            if (accept) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_wdata;
                PSTRB  <= cmd_write ? cmd_strb : '0;
            end
            if (xfer_end) begin
                rsp_rdata <= (PWRITE || xfer_tmo) ? '0 : PRDATA;
                rsp_err   <= PSLVERR || xfer_tmo;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed and randomized transfers with
// a transaction-level model that predicts the bus timeline of every transfer.
module tb_apb_master;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TMO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    apb_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;

    // Model state: what the bus fields and response outputs should hold now
    logic [AW-1:0] exp_paddr  = '0;
    logic          exp_pwrite = 1'b0;
    logic [DW-1:0] exp_pwdata = '0;
    logic [SW-1:0] exp_pstrb  = '0;
    logic [DW-1:0] exp_rdata  = '0;
    logic          exp_err    = 1'b0;
    logic          pending    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle(input string ph, input logic psel_e, input logic pen_e, input logic rv_e);
        check_eq({ph, ".psel"},      32'(PSEL),      32'(psel_e));
        check_eq({ph, ".penable"},   32'(PENABLE),   32'(pen_e));
        check_eq({ph, ".cmd_ready"}, 32'(cmd_ready), 32'(!psel_e));
        check_eq({ph, ".rsp_valid"}, 32'(rsp_valid), 32'(rv_e));
        check_eq({ph, ".rsp_rdata"}, rsp_rdata,      exp_rdata);
        check_eq({ph, ".rsp_err"},   32'(rsp_err),   32'(exp_err));
        check_eq({ph, ".paddr"},     PADDR,          exp_paddr);
        check_eq({ph, ".pwrite"},    32'(PWRITE),    32'(exp_pwrite));
        check_eq({ph, ".pwdata"},    PWDATA,         exp_pwdata);
        check_eq({ph, ".pstrb"},     32'(PSTRB),     32'(exp_pstrb));
    endtask

    task automatic junk_slave();
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle_cycle();
        cmd_valid = 1'b0;
        junk_slave();
        @(negedge PCLK);
        check_cycle("idle", 1'b0, 1'b0, pending);
        pending = 1'b0;
        next_cycle();
    endtask

    // One transfer: w = number of ACCESS cycles with PREADY low before PREADY=1
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] strb, input int unsigned w,
                           input logic [DW-1:0] rdata, input logic err, input logic hold);
        int unsigned n_acc;
        logic        tmo;
        tmo   = TMO_EN && (w >= TMO);
        n_acc = tmo ? TMO : w + 1;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        junk_slave();
        @(negedge PCLK);
        check_cycle("accept", 1'b0, 1'b0, pending);
        pending = 1'b0;
        next_cycle();

        cmd_valid  = hold;
        cmd_write  = 1'($urandom);
        cmd_addr   = $urandom;
        cmd_wdata  = $urandom;
        cmd_strb   = SW'($urandom);
        exp_paddr  = addr;
        exp_pwrite = wr;
        exp_pwdata = wdata;
        exp_pstrb  = wr ? strb : '0;
        junk_slave();
        @(negedge PCLK);
        check_cycle("setup", 1'b1, 1'b0, 1'b0);
        next_cycle();

        for (int unsigned k = 0; k < n_acc; k++) begin
            PREADY  = (k == w);
            PSLVERR = (k == w) ? err : 1'($urandom);
            PRDATA  = (k == w) ? rdata : $urandom;
            @(negedge PCLK);
            check_cycle("access", 1'b1, 1'b1, 1'b0);
            next_cycle();
        end

        pending   = 1'b1;
        exp_rdata = (tmo || wr) ? '0 : rdata;
        exp_err   = tmo ? 1'b1 : err;
    endtask

    task automatic model_reset();
        exp_paddr  = '0;
        exp_pwrite = 1'b0;
        exp_pwdata = '0;
        exp_pstrb  = '0;
        exp_rdata  = '0;
        exp_err    = 1'b0;
        pending    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        next_cycle();
        next_cycle();
        @(negedge PCLK);
        check_cycle("reset", 1'b0, 1'b0, 1'b0);
        PRESETn = 1'b1;
        next_cycle();
        idle_cycle();

        // Zero-wait write
        do_xfer(1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle_cycle();
        // Read with three stalled ACCESS cycles
        do_xfer(1'b0, 32'h14, 32'h1234_5678, 4'hF, 3, 32'h0000_0055, 1'b0, 1'b0);
        idle_cycle();
        // Slave error on a write, then a clean transfer
        do_xfer(1'b1, 32'h20, 32'h0BAD_0BAD, 4'h3, 0, 32'h0, 1'b1, 1'b0);
        do_xfer(1'b1, 32'h24, 32'h600D_600D, 4'hC, 1, 32'h0, 1'b0, 1'b0);
        idle_cycle();
        // Back-to-back with cmd_valid held between commands
        do_xfer(1'b0, 32'h30, 32'h0, 4'hF, 0, 32'hCAFE_0030, 1'b0, 1'b1);
        do_xfer(1'b0, 32'h34, 32'h0, 4'hF, 0, 32'hCAFE_0034, 1'b1, 1'b1);
        idle_cycle();

        // Randomized transfers
        for (int unsigned i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0) idle_cycle();
            do_xfer(1'($urandom), $urandom, $urandom, SW'($urandom),
                    $urandom_range(TMO_EN ? TMO + 2 : 6), $urandom, 1'($urandom),
                    1'($urandom));
        end
        idle_cycle();

        // Reset in the middle of an ACCESS phase
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h40;
        cmd_wdata = 32'h1111_2222;
        cmd_strb  = 4'hF;
        PREADY    = 1'b0;
        next_cycle();
        cmd_valid = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge PCLK);
        check_eq("midrst.penable", 32'(PENABLE), 32'd1);
        PRESETn = 1'b0;
        PREADY  = 1'b1;
        next_cycle();
        model_reset();
        @(negedge PCLK);
        check_cycle("midrst", 1'b0, 1'b0, 1'b0);
        PRESETn = 1'b1;
        next_cycle();
        idle_cycle();
        idle_cycle();

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never ready: forced error response, bus released afterwards
        do_xfer(1'b0, 32'h50, 32'h0, 4'hF, 1000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle_cycle();
        idle_cycle();
        // Ready on the last permitted cycle completes normally
        do_xfer(1'b0, 32'h54, 32'h0, 4'hF, TMO - 1, 32'h0000_0077, 1'b0, 1'b0);
        idle_cycle();
`endif
        do_xfer(1'b0, 32'h60, 32'h0, 4'hF, 0, 32'h0000_0099, 1'b0, 1'b0);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
